disp_scan_ctrl: RTL and testbench

//  Scan sequencer for the 16-digit, two-bank seven-segment display mux (8 top + 8 bottom digits).

---
 rtl/disp_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 16-digit two-bank seven-segment scan sequencer.
// Adds a blank gap before each digit, applies PWM brightness and frame-aligned config updates.
module disp_scan_ctrl #(
  parameter int SLOT_CYCLES  = 6250,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_cfg_valid,
  input  logic [15:0] i_cfg_mask,
  input  logic [3:0]  i_cfg_bright,
  output logic        o_cfg_ready,
  output logic [3:0]  o_digit_sel,
  output logic        o_bank,
  output logic [7:0]  o_an,
  output logic        o_frame_done
);
  localparam int SW = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
  localparam int BW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
  state_t        r_state, w_state;
  logic [BW-1:0] r_bcnt, w_bcnt;
  logic [SW-1:0] r_scnt, w_scnt;
  logic [3:0]    r_slot, w_slot;
  logic [15:0]   r_mask, w_mask, r_pmask, w_pmask;
  logic [3:0]    r_bright, w_bright, r_pbright, w_pbright;
  logic          r_pvld, w_pvld;
  logic [3:0]    w_sel;
  logic [7:0]    w_an;
  logic          w_done, w_xfer, w_apply;
  logic [4:0]    w_low, w_nxt;
  // {found, index} of the lowest set bit
  function automatic logic [4:0] lowest(input logic [15:0] m);
    logic [4:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--)
      if (m[i]) r = {1'b1, 4'(i)};
    return r;
  endfunction
  function automatic logic [4:0] next_above(input logic [15:0] m, input logic [3:0] s);
    logic [4:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--)
      if (m[i] && i > int'(s)) r = {1'b1, 4'(i)};
    return r;
  endfunction
  always_comb begin
    w_state   = r_state;
    w_bcnt    = r_bcnt;
    w_scnt    = r_scnt;
    w_slot    = r_slot;
    w_sel     = o_digit_sel;
    w_mask    = r_mask;
    w_bright  = r_bright;
    w_done    = 1'b0;
    w_apply   = 1'b0;
    w_xfer    = i_cfg_valid && o_cfg_ready;
    w_low     = lowest(r_pvld ? r_pmask : r_mask);
    w_nxt     = next_above(r_mask, o_digit_sel);
    if (!i_en && r_state != IDLE) begin
      w_state = IDLE;
      w_bcnt  = '0;
      w_scnt  = '0;
      w_slot  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_apply = r_pvld;
          if (i_en && w_low[4]) begin
            w_state = BLANK;
            w_sel   = w_low[3:0];
            w_bcnt  = '0;
          end
        end
        BLANK: begin
          w_state = r_bcnt == BLANK_LAST ? ON : BLANK;
          w_bcnt  = r_bcnt == BLANK_LAST ? '0 : r_bcnt + BW'(1);
          w_scnt  = '0;
          w_slot  = '0;
        end
        ON: begin
          w_scnt = r_scnt == SLOT_LAST ? '0 : r_scnt + SW'(1);
          w_slot = r_scnt == SLOT_LAST ? r_slot + 4'd1 : r_slot;
          if (r_scnt == SLOT_LAST && r_slot == 4'hF) begin
            w_state = BLANK;
            if (w_nxt[4]) w_sel = w_nxt[3:0];
            else begin
              // frame end: the only point besides IDLE where config may change
              w_done  = 1'b1;
              w_apply = r_pvld;
              w_sel   = w_low[4] ? w_low[3:0] : o_digit_sel;
              w_state = w_low[4] ? BLANK : IDLE;
            end
          end
        end
        default: w_state = IDLE;
      endcase
    end
    if (w_apply) begin
      w_mask   = r_pmask;
      w_bright = r_pbright;
    end
    w_pvld    = w_xfer | (r_pvld & ~w_apply);
    w_pmask   = w_xfer ? i_cfg_mask : r_pmask;
    w_pbright = w_xfer ? i_cfg_bright : r_pbright;
    w_an      = (w_state == ON && w_slot <= w_bright) ? ~(8'b1 << w_sel[2:0]) : 8'hFF;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_bcnt       <= '0;
      r_scnt       <= '0;
      r_slot       <= '0;
      r_mask       <= 16'hFFFF;
      r_bright     <= 4'hF;
      r_pmask      <= '0;
      r_pbright    <= '0;
      r_pvld       <= 1'b0;
      o_cfg_ready  <= 1'b1;
      o_digit_sel  <= '0;
      o_bank       <= 1'b0;
      o_an         <= 8'hFF;
      o_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_bcnt       <= w_bcnt;
      r_scnt       <= w_scnt;
      r_slot       <= w_slot;
      r_mask       <= w_mask;
      r_bright     <= w_bright;
      r_pmask      <= w_pmask;
      r_pbright    <= w_pbright;
      r_pvld       <= w_pvld;
      o_cfg_ready  <= ~w_pvld;
      o_digit_sel  <= w_sel;
      o_bank       <= w_sel[3];
      o_an         <= w_an;
      o_frame_done <= w_done;
    end
  end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: randomized bench for disp_scan_ctrl against a timeline-based reference model.
module tb_disp_scan_ctrl;
  localparam int SLOT  = 2;
  localparam int BLANK = 1;
  localparam int DWELL = BLANK + 16 * SLOT;
  logic        clk = 1'b0;
  logic        rst_n, en, cfg_valid;
  logic [15:0] cfg_mask;
  logic [3:0]  cfg_bright;
  logic        cfg_ready, bank, frame_done;
  logic [3:0]  digit_sel;
  logic [7:0]  an;
  int vec = 0;
  int err = 0;
  // model: a digit's dwell is DWELL cycles, m_e counts elapsed cycles within it
  logic        m_run, m_pvld, m_ready, m_done, m_xfer;
  logic [3:0]  m_dig, m_bright, m_pbright;
  logic [15:0] m_mask, m_pmask;
  int          m_e;
  disp_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_cfg_valid(cfg_valid),
    .i_cfg_mask(cfg_mask), .i_cfg_bright(cfg_bright), .o_cfg_ready(cfg_ready),
    .o_digit_sel(digit_sel), .o_bank(bank), .o_an(an), .o_frame_done(frame_done)
  );
  always #5 clk = ~clk;
  wire [14:0] dut_v = {cfg_ready, digit_sel, bank, an, frame_done};
  function automatic int first_from(input logic [15:0] m, input int start);
    for (int i = start; i < 16; i++) if (m[i]) return i;
    return -1;
  endfunction
  function automatic logic [14:0] exp_v();
    logic [7:0] a;
    a = 8'hFF;
    if (m_run && m_e >= BLANK && (m_e - BLANK) / SLOT <= int'(m_bright)) a[m_dig[2:0]] = 1'b0;
    return {m_ready, m_dig, m_dig[3], a, m_done};
  endfunction
  task automatic model_reset();
    m_run = 0; m_pvld = 0; m_ready = 1; m_done = 0; m_xfer = 0;
    m_dig = 0; m_bright = 4'hF; m_pbright = 0; m_mask = 16'hFFFF; m_pmask = 0; m_e = 0;
  endtask
  task automatic apply_pending();
    if (m_pvld) begin
      m_mask = m_pmask;
      m_bright = m_pbright;
      m_pvld = 0;
    end
  endtask
  task automatic tick();
    int nx;
    m_xfer = cfg_valid && m_ready;
    m_done = 0;
    if (!m_run) begin
      apply_pending();
      if (en && m_mask != 0) begin
        m_run = 1; m_dig = 4'(first_from(m_mask, 0)); m_e = 0;
      end
    end else if (!en) begin
      m_run = 0; m_e = 0;
    end else if (m_e == DWELL - 1) begin
      nx = first_from(m_mask, int'(m_dig) + 1);
      m_e = 0;
      if (nx >= 0) m_dig = 4'(nx);
      else begin
        m_done = 1;
        apply_pending();
        if (m_mask != 0) m_dig = 4'(first_from(m_mask, 0));
        else m_run = 0;
      end
    end else m_e++;
    if (m_xfer) begin
      m_pvld = 1; m_pmask = cfg_mask; m_pbright = cfg_bright;
    end
    m_ready = !m_pvld;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0; en = 0; cfg_valid = 0; cfg_mask = 0; cfg_bright = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (dut_v !== {1'b1, 4'h0, 1'b0, 8'hFF, 1'b0}) begin
      err++; $display("FAIL reset got %h exp %h", dut_v, {1'b1, 4'h0, 1'b0, 8'hFF, 1'b0});
    end
  endtask
  task automatic test_default_frame();
    int pulses = 0;
    en = 1; rst_n = 1;
    repeat (2 * 528) begin
      tick();
      pulses += int'(frame_done);
      vec++;
      if (dut_v !== exp_v()) begin err++; $display("FAIL default_frame t=%0t got %h exp %h", $time, dut_v, exp_v()); end
    end
    vec++;
    if (pulses !== 1) begin err++; $display("FAIL frame_done_count got %0d exp 1", pulses); end
  endtask
  task automatic test_cfg_midframe();
    repeat (100) tick();
    cfg_valid = 1; cfg_mask = 16'h8101; cfg_bright = 4'd3;
    tick();
    cfg_valid = 0;
    repeat (700) begin
      tick();
      vec++;
      if (dut_v !== exp_v()) begin err++; $display("FAIL cfg_midframe t=%0t got %h exp %h", $time, dut_v, exp_v()); end
    end
  endtask
  task automatic test_back_to_back();
    logic [15:0] b_mask;
    logic [3:0]  b_bright;
    int stage = 0;
    b_mask = 16'($urandom) | 16'h0020;
    b_bright = 4'($urandom);
    cfg_valid = 1; cfg_mask = 16'($urandom) | 16'h0001; cfg_bright = 4'($urandom);
    repeat (1500) begin
      tick();
      if (m_xfer && stage == 0) begin stage = 1; cfg_mask = b_mask; cfg_bright = b_bright; end
      else if (m_xfer && stage == 1) begin stage = 2; cfg_valid = 0; end
      vec++;
      if (dut_v !== exp_v()) begin err++; $display("FAIL back_to_back t=%0t got %h exp %h", $time, dut_v, exp_v()); end
    end
    vec++;
    if (stage != 2) begin err++; $display("FAIL back_to_back_accept got stage %0d exp 2", stage); end
    cfg_valid = 0;
  endtask
  task automatic test_mask_zero();
    int pulses = 0;
    cfg_valid = 1; cfg_mask = 16'h0000; cfg_bright = 4'($urandom);
    for (int i = 0; i < 1400; i++) begin
      tick();
      if (m_xfer) cfg_valid = 0;
      if (i >= 800) pulses += int'(frame_done);
      vec++;
      if (dut_v !== exp_v()) begin err++; $display("FAIL mask_zero t=%0t got %h exp %h", $time, dut_v, exp_v()); end
    end
    vec++;
    if (pulses !== 0 || an !== 8'hFF) begin err++; $display("FAIL mask_zero_idle got pulses %0d an %h exp 0 FF", pulses, an); end
    cfg_valid = 1; cfg_mask = 16'hFFFF; cfg_bright = 4'hF;
    repeat (50) begin
      tick();
      if (m_xfer) cfg_valid = 0;
      vec++;
      if (dut_v !== exp_v()) begin err++; $display("FAIL mask_restore t=%0t got %h exp %h", $time, dut_v, exp_v()); end
    end
  endtask
  task automatic test_en_drop();
    int budget = 3000;
    while (!(m_run && m_dig == 4'd5 && m_e >= BLANK + 4) && budget > 0) begin
      tick();
      budget--;
      vec++;
      if (dut_v !== exp_v()) begin err++; $display("FAIL en_wait t=%0t got %h exp %h", $time, dut_v, exp_v()); end
    end
    vec++;
    if (budget == 0) begin err++; $display("FAIL en_wait_timeout got no digit5 exp digit5 ON"); end
    en = 0;
    repeat (6) begin
      tick();
      vec++;
      if (dut_v !== exp_v()) begin err++; $display("FAIL en_low t=%0t got %h exp %h", $time, dut_v, exp_v()); end
    end
    en = 1;
    repeat (120) begin
      tick();
      vec++;
      if (dut_v !== exp_v()) begin err++; $display("FAIL en_restart t=%0t got %h exp %h", $time, dut_v, exp_v()); end
    end
  endtask
  task automatic test_async_reset();
    repeat (40) tick();
    cfg_valid = 1; cfg_mask = 16'h0040; cfg_bright = 4'd2;
    tick();
    cfg_valid = 0;
    repeat (5) tick();
    #3 rst_n = 0;
    #1;
    model_reset();
    vec++;
    if (dut_v !== {1'b1, 4'h0, 1'b0, 8'hFF, 1'b0}) begin
      err++; $display("FAIL async_reset got %h exp %h", dut_v, {1'b1, 4'h0, 1'b0, 8'hFF, 1'b0});
    end
    @(posedge clk);
    #1 rst_n = 1;
    repeat (600) begin
      tick();
      vec++;
      if (dut_v !== exp_v()) begin err++; $display("FAIL after_reset t=%0t got %h exp %h", $time, dut_v, exp_v()); end
    end
  endtask
  task automatic test_random();
    repeat (3000) begin
      en = $urandom_range(0, 99) < 97;
      if (!cfg_valid && $urandom_range(0, 29) == 0) begin
        cfg_valid = 1;
        cfg_mask = $urandom_range(0, 9) == 0 ? 16'h0000 : 16'($urandom);
        cfg_bright = 4'($urandom);
      end
      tick();
      if (m_xfer) cfg_valid = 0;
      vec++;
      if (dut_v !== exp_v()) begin err++; $display("FAIL random t=%0t got %h exp %h", $time, dut_v, exp_v()); end
    end
  endtask
  initial begin
    test_reset();
    test_default_frame();
    test_cfg_midframe();
    test_back_to_back();
    test_mask_zero();
    test_en_drop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
